timer_multi_ch: RTL and testbench

- N-channel general-purpose timer with an integrated CSR slave on the standard local bus (waddr/wdata/wen/wstrb/wready/raddr/ren/rdata/rvalid).
- Successor to the single-channel timer register bank. Adds parametrised channel count and counter width, the counting datapath itself, and readable config.
- Adds write-1-to-clear status and per-channel interrupts.
- Sits on the peripheral bus next to the I2C/UART blocks; irq goes to the interrupt controller.

---
 rtl/timer_multi_ch.sv | 215 +++++++++++++++++++++
 tb/tb_timer_multi_ch.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_multi_ch.sv
// N-channel prescaled up/down timer with local-bus CSRs, w1c status and per-channel irq.
// Define TIMER_SHADOW_EN to buffer PER/PSC writes until the next wrap, UD load or while disabled.
module timer_multi_ch #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int STRB_W = DATA_W/8,
    parameter int N_CH   = 4,
    parameter int CNT_W  = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_W-1:0]       waddr,
    input  logic [DATA_W-1:0]       wdata,
    input  logic                    wen,
    input  logic [STRB_W-1:0]       wstrb,
    output logic                    wready,
    input  logic [ADDR_W-1:0]       raddr,
    input  logic                    ren,
    output logic [DATA_W-1:0]       rdata,
    output logic                    rvalid,
    output logic [N_CH-1:0]         irq,
    output logic [N_CH*CNT_W-1:0]   cnt_out
);
    localparam logic [4:0] OFF_CFG  = 5'h00;
    localparam logic [4:0] OFF_PSC  = 5'h04;
    localparam logic [4:0] OFF_PER  = 5'h08;
    localparam logic [4:0] OFF_CNT  = 5'h0C;
    localparam logic [4:0] OFF_STS  = 5'h10;
    localparam logic [4:0] OFF_LOAD = 5'h14;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] PSC_RST = CNT_W'(32'h1B);
    localparam logic [CNT_W-1:0] PER_RST = CNT_W'(32'hFFFF);

    function automatic logic [DATA_W-1:0] merge_bytes(input logic [DATA_W-1:0] old_v,
                                                      input logic [DATA_W-1:0] new_v,
                                                      input logic [STRB_W-1:0] strb);
        logic [DATA_W-1:0] v;
        v = old_v;
        for (int b = 0; b < STRB_W; b++) begin
            if (strb[b]) v[b*8 +: 8] = new_v[b*8 +: 8];
        end
        return v;
    endfunction

    logic [4:0]        w_off;
    logic [4:0]        r_off;
    logic [DATA_W-1:0] ch_rd [N_CH];
    logic [DATA_W-1:0] rd_mux;
    logic [DATA_W-1:0] rdata_q;
    logic              rvalid_q;

    assign w_off  = waddr[4:0];
    assign r_off  = raddr[4:0];
    assign wready = 1'b1;

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        logic             en_q, en_d, ar_q, ar_d, dir_q, dir_d;
        logic [3:0]       ie_q, ie_d, sts_q, sts_d;
        logic [CNT_W-1:0] psc_q, psc_d, per_q, per_d, load_q, load_d;
        logic [CNT_W-1:0] cnt_q, cnt_d, pcnt_q, pcnt_d;
        logic [CNT_W-1:0] psc_act, per_act;
        logic             irq_q;
        logic             w_sel, wr_cfg, wr_psc, wr_per, wr_sts, wr_load;
        logic             ud, tick, tick_eff, wrap, of_set, uf_set, err_set;
        logic [DATA_W-1:0] rd_w;

        assign w_sel   = wen && (waddr[ADDR_W-1:5] == (ADDR_W-5)'(gi));
        assign wr_cfg  = w_sel && (w_off == OFF_CFG);
        assign wr_psc  = w_sel && (w_off == OFF_PSC);
        assign wr_per  = w_sel && (w_off == OFF_PER);
        assign wr_sts  = w_sel && (w_off == OFF_STS);
        assign wr_load = w_sel && (w_off == OFF_LOAD);

        assign ud       = wr_cfg && wstrb[0] && wdata[5];
        // >= keeps the prescaler from running away if PSC is lowered below psc_cnt
        assign tick     = en_q && (pcnt_q >= psc_act);
        assign tick_eff = tick && !ud;
        assign wrap     = dir_q ? (cnt_q == '0) : (cnt_q >= per_act);
        assign of_set   = tick_eff && wrap && !dir_q;
        assign uf_set   = tick_eff && wrap && dir_q;
        assign err_set  = ud && (load_q > per_q);

`ifdef TIMER_SHADOW_EN
        logic [CNT_W-1:0] psc_act_q, per_act_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                psc_act_q <= PSC_RST;
                per_act_q <= PER_RST;
            end else if (!en_q || ud || (tick_eff && wrap)) begin
                psc_act_q <= psc_q;
                per_act_q <= per_q;
            end
        end

        assign psc_act = psc_act_q;
        assign per_act = per_act_q;
`else
        assign psc_act = psc_q;
        assign per_act = per_q;
`endif

        always_comb begin
            en_d   = en_q;
            ar_d   = ar_q;
            dir_d  = dir_q;
            ie_d   = ie_q;
            psc_d  = psc_q;
            per_d  = per_q;
            load_d = load_q;
            cnt_d  = cnt_q;
            pcnt_d = pcnt_q;
            sts_d  = sts_q;
            if (tick_eff) begin
                pcnt_d = '0;
                if (wrap) begin
                    if (ar_q) cnt_d = dir_q ? per_act : '0;
                    else      en_d  = 1'b0;
                end else begin
                    cnt_d = dir_q ? (cnt_q - CNT_ONE) : (cnt_q + CNT_ONE);
                end
            end else if (en_q && !ud) begin
                pcnt_d = pcnt_q + CNT_ONE;
            end
            if (ud) begin
                cnt_d  = load_q;
                pcnt_d = '0;
            end
            // a bus write to EN overrides the hardware one-shot clear
            if (wr_cfg && wstrb[0]) begin
                en_d  = wdata[0];
                ar_d  = wdata[1];
                dir_d = wdata[4];
            end
            if (wr_cfg && wstrb[1]) ie_d = wdata[11:8];
            if (wr_psc)  psc_d  = CNT_W'(merge_bytes(DATA_W'(psc_q), wdata, wstrb));
            if (wr_per)  per_d  = CNT_W'(merge_bytes(DATA_W'(per_q), wdata, wstrb));
            if (wr_load) load_d = CNT_W'(merge_bytes(DATA_W'(load_q), wdata, wstrb));
            if (wr_sts && wstrb[0]) sts_d = sts_q & ~wdata[3:0];
            sts_d = sts_d | {err_set, ud, uf_set, of_set};
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                en_q   <= 1'b0;
                ar_q   <= 1'b1;
                dir_q  <= 1'b0;
                ie_q   <= '0;
                psc_q  <= PSC_RST;
                per_q  <= PER_RST;
                load_q <= '0;
                cnt_q  <= '0;
                pcnt_q <= '0;
                sts_q  <= '0;
                irq_q  <= 1'b0;
            end else begin
                en_q   <= en_d;
                ar_q   <= ar_d;
                dir_q  <= dir_d;
                ie_q   <= ie_d;
                psc_q  <= psc_d;
                per_q  <= per_d;
                load_q <= load_d;
                cnt_q  <= cnt_d;
                pcnt_q <= pcnt_d;
                sts_q  <= sts_d;
                irq_q  <= |(sts_q & ie_q);
            end
        end

        always_comb begin
            rd_w = '0;
            case (r_off)
                OFF_CFG: begin
                    rd_w[0]    = en_q;
                    rd_w[1]    = ar_q;
                    rd_w[4]    = dir_q;
                    rd_w[11:8] = ie_q;
                end
                OFF_PSC:  rd_w = DATA_W'(psc_q);
                OFF_PER:  rd_w = DATA_W'(per_q);
                OFF_CNT:  rd_w = DATA_W'(cnt_q);
                OFF_STS:  rd_w[3:0] = sts_q;
                OFF_LOAD: rd_w = DATA_W'(load_q);
                default:  rd_w = '0;
            endcase
        end

        assign ch_rd[gi]                     = rd_w;
        assign irq[gi]                       = irq_q;
        assign cnt_out[gi*CNT_W +: CNT_W]    = cnt_q;
    end

    always_comb begin
        rd_mux = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (raddr[ADDR_W-1:5] == (ADDR_W-5)'(c)) rd_mux = ch_rd[c];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            rdata_q  <= ren ? rd_mux : '0;
            rvalid_q <= ren;
        end
    end

    assign rdata  = rdata_q;
    assign rvalid = rvalid_q;

endmodule

// File: tb/tb_timer_multi_ch.sv
// Bench for timer_multi_ch: register table, directed corner sequences, and randomized
// channel runs checked against a closed-form counting model.
module tb_timer_multi_ch;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int NC = 4;
    localparam int CW = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic [AW-1:0]    waddr, raddr;
    logic [DW-1:0]    wdata;
    logic             wen, ren;
    logic [DW/8-1:0]  wstrb;
    logic             wready, rvalid;
    logic [DW-1:0]    rdata;
    logic [NC-1:0]    irq;
    logic [NC*CW-1:0] cnt_out;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    timer_multi_ch #(.ADDR_W(AW), .DATA_W(DW), .STRB_W(DW/8), .N_CH(NC), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .waddr(waddr), .wdata(wdata), .wen(wen), .wstrb(wstrb), .wready(wready),
        .raddr(raddr), .ren(ren), .rdata(rdata), .rvalid(rvalid),
        .irq(irq), .cnt_out(cnt_out)
    );

    initial begin
        #400000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    // Called at a negedge; the write lands on the following posedge, returns at the next negedge.
    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        wen = 1'b1; waddr = a; wdata = d; wstrb = s;
        @(negedge clk);
        wen = 1'b0;
        $display("WR addr=%h data=%h strb=%h", a, d, s);
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        ren = 1'b1; raddr = a;
        @(negedge clk);
        chk("rvalid_pulse", {31'b0, rvalid}, 32'h1);
        d = rdata;
        ren = 1'b0;
        $display("RD addr=%h data=%h", a, d);
    endtask

    task automatic rd_chk(input string nm, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] d;
        rd(a, d);
        chk(nm, d, exp);
    endtask

    function automatic logic [31:0] cnt_of(input int ch);
        return cnt_out[ch*CW +: CW];
    endfunction

    // Timer state m cycles after an UD+EN write, derived from the number of elapsed ticks.
    function automatic void model(input int p, input int per, input int l, input int dir,
                                  input int ar, input int m,
                                  output int cnt, output bit wrapped, output bit en);
        int n, thr;
        n = m / (p + 1);
        if (dir == 0) begin
            thr = (l > per) ? 1 : per - l + 1;
            if (ar != 0) cnt = (l > per) ? ((n == 0) ? l : (n - 1) % (per + 1)) : (l + n) % (per + 1);
            else         cnt = (l > per) ? l : ((l + n > per) ? per : l + n);
        end else begin
            thr = l + 1;
            if (ar != 0) cnt = (n <= l) ? l - n : per - ((n - l - 1) % (per + 1));
            else         cnt = (n <= l) ? l - n : 0;
        end
        wrapped = (n >= thr);
        en = (ar != 0) ? 1'b1 : !wrapped;
    endfunction

    typedef struct {
        bit          is_wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [24];

    int ch, p, per, l, dir, ar, ie, mx, base, ecnt;
    bit wrp, een;
    logic [31:0] rv, exp_sts, exp_cfg;

    initial begin
        tbl[0]  = '{1'b0, 32'h00, 32'h0,        4'h0, 32'h2};
        tbl[1]  = '{1'b0, 32'h04, 32'h0,        4'h0, 32'h1B};
        tbl[2]  = '{1'b0, 32'h08, 32'h0,        4'h0, 32'hFFFF};
        tbl[3]  = '{1'b0, 32'h0C, 32'h0,        4'h0, 32'h0};
        tbl[4]  = '{1'b0, 32'h10, 32'h0,        4'h0, 32'h0};
        tbl[5]  = '{1'b0, 32'h14, 32'h0,        4'h0, 32'h0};
        tbl[6]  = '{1'b1, 32'h64, 32'h12345678, 4'h2, 32'h0};
        tbl[7]  = '{1'b0, 32'h64, 32'h0,        4'h0, 32'h561B};
        tbl[8]  = '{1'b1, 32'h74, 32'hAABBCCDD, 4'hF, 32'h0};
        tbl[9]  = '{1'b0, 32'h74, 32'h0,        4'h0, 32'hAABBCCDD};
        tbl[10] = '{1'b1, 32'h60, 32'h00000F32, 4'hF, 32'h0};
        tbl[11] = '{1'b0, 32'h60, 32'h0,        4'h0, 32'hF12};
        tbl[12] = '{1'b0, 32'h6C, 32'h0,        4'h0, 32'hAABBCCDD};
        tbl[13] = '{1'b0, 32'h70, 32'h0,        4'h0, 32'hC};
        tbl[14] = '{1'b1, 32'h70, 32'h4,        4'hF, 32'h0};
        tbl[15] = '{1'b0, 32'h70, 32'h0,        4'h0, 32'h8};
        tbl[16] = '{1'b1, 32'h6C, 32'h0,        4'hF, 32'h0};
        tbl[17] = '{1'b0, 32'h6C, 32'h0,        4'h0, 32'hAABBCCDD};
        tbl[18] = '{1'b1, 32'h80, 32'h1,        4'hF, 32'h0};
        tbl[19] = '{1'b0, 32'h80, 32'h0,        4'h0, 32'h0};
        tbl[20] = '{1'b0, 32'h78, 32'h0,        4'h0, 32'h0};
        tbl[21] = '{1'b0, 32'h18, 32'h0,        4'h0, 32'h0};
        tbl[22] = '{1'b1, 32'h64, 32'hFFFFFFFF, 4'h0, 32'h0};
        tbl[23] = '{1'b0, 32'h64, 32'h0,        4'h0, 32'h561B};

        rst = 1'b1; wen = 1'b0; ren = 1'b0; waddr = '0; raddr = '0; wdata = '0; wstrb = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_rvalid", {31'b0, rvalid}, 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_irq", {28'b0, irq}, 32'h0);
        chk("rst_wready", {31'b0, wready}, 32'h1);

        for (int i = 0; i < 24; i++) begin
            if (tbl[i].is_wr) wr(tbl[i].addr, tbl[i].data, tbl[i].strb);
            else              rd_chk($sformatf("tbl%0d", i), tbl[i].addr, tbl[i].exp);
        end
        @(negedge clk);
        chk("rvalid_drop", {31'b0, rvalid}, 32'h0);
        chk("rdata_idle", rdata, 32'h0);
        chk("tbl_irq3", {28'b0, irq}, 32'h8);

        // ch1: up count with auto-reload, OF irq and w1c
        wr(32'h24, 0, 4'hF); wr(32'h28, 3, 4'hF); wr(32'h20, 32'h103, 4'hF);
        for (int m = 0; m <= 5; m++) begin
            if (m > 0) @(negedge clk);
            chk($sformatf("ch1_cnt_m%0d", m), cnt_of(1), m % 4);
            if (m == 4) chk("ch1_irq_lag", {31'b0, irq[1]}, 32'h0);
            if (m == 5) chk("ch1_irq_set", {31'b0, irq[1]}, 32'h1);
        end
        wr(32'h30, 1, 4'hF);
        chk("ch1_irq_hold", {31'b0, irq[1]}, 32'h1);
        @(negedge clk);
        chk("ch1_irq_drop", {31'b0, irq[1]}, 32'h0);
        rd_chk("ch1_sts_clr", 32'h30, 32'h0);

        // ch2: down count, one-shot, prescaled by 3
        wr(32'h44, 2, 4'hF); wr(32'h48, 5, 4'hF); wr(32'h54, 2, 4'hF);
        wr(32'h40, 32'h30, 4'hF); wr(32'h40, 32'h11, 4'hF);
        for (int m = 0; m <= 11; m++) begin
            if (m > 0) @(negedge clk);
            chk($sformatf("ch2_cnt_m%0d", m), cnt_of(2), (m / 3 >= 2) ? 0 : 2 - m / 3);
        end
        rd_chk("ch2_sts", 32'h50, 32'h6);
        rd_chk("ch2_en_clr", 32'h40, 32'h10);

        // ch0: LOAD above PER flags ERR, first tick wraps
        wr(32'h14, 9, 4'hF); wr(32'h08, 5, 4'hF); wr(32'h00, 32'h22, 4'hF);
        rd_chk("ch0_cnt_load", 32'h0C, 32'h9);
        rd_chk("ch0_sts_err", 32'h10, 32'hC);
        wr(32'h04, 0, 4'hF); wr(32'h00, 32'h3, 4'hF);
        chk("ch0_cnt_m0", cnt_of(0), 9);
        @(negedge clk);
        chk("ch0_cnt_wrap", cnt_of(0), 0);
        wr(32'h00, 0, 4'hF);
        rd_chk("ch0_sts_of", 32'h10, 32'hD);

        // same-cycle collisions: set beats w1c, UD beats tick
        wr(32'h10, 32'hF, 4'hF); wr(32'h08, 3, 4'hF); wr(32'h14, 0, 4'hF);
        wr(32'h00, 32'h23, 4'hF);
        repeat (3) @(negedge clk);
        wr(32'h10, 1, 4'hF);
        rd_chk("set_beats_w1c", 32'h10, 32'h5);
        wr(32'h14, 2, 4'hF);
        wr(32'h00, 32'h23, 4'hF);
        chk("ud_beats_tick", cnt_of(0), 2);
        @(negedge clk);
        chk("ud_then_count", cnt_of(0), 3);

`ifdef TIMER_SHADOW_EN
        wr(32'h60, 0, 4'hF); wr(32'h70, 32'hF, 4'hF); wr(32'h64, 0, 4'hF);
        wr(32'h68, 3, 4'hF); wr(32'h74, 0, 4'hF); wr(32'h60, 32'h23, 4'hF);
        chk("shd_m0", cnt_of(3), 0);
        @(negedge clk);
        wr(32'h68, 7, 4'hF);
        rd_chk("shd_readback", 32'h68, 32'h7);
        chk("shd_m3", cnt_of(3), 3);
        @(negedge clk);
        chk("shd_wrap_old", cnt_of(3), 0);
        repeat (7) @(negedge clk);
        chk("shd_peak_new", cnt_of(3), 7);
        @(negedge clk);
        chk("shd_wrap_new", cnt_of(3), 0);
`endif

        // randomized single-channel runs against the tick-count model
        for (int t = 0; t < 40; t++) begin
            ch  = $urandom_range(0, NC - 1);
            p   = $urandom_range(0, 3);
            per = $urandom_range(0, 7);
            l   = $urandom_range(0, 9);
            dir = $urandom_range(0, 1);
            ar  = $urandom_range(0, 1);
            ie  = $urandom_range(0, 15);
            mx  = $urandom_range(1, 30);
            base = ch * 32;
            wr(base, 0, 4'hF);
            wr(base + 16, 32'hF, 4'hF);
            wr(base + 4, p, 4'hF);
            wr(base + 8, per, 4'hF);
            wr(base + 20, l, 4'hF);
            wr(base, 32'h21 | (ar << 1) | (dir << 4) | (ie << 8), 4'hF);
            for (int m = 0; m <= mx; m++) begin
                if (m > 0) @(negedge clk);
                model(p, per, l, dir, ar, m, ecnt, wrp, een);
                chk($sformatf("rnd%0d_cnt_m%0d", t, m), cnt_of(ch), ecnt);
            end
            model(p, per, l, dir, ar, mx - 1, ecnt, wrp, een);
            exp_sts = {28'b0, (l > per), 1'b1, wrp && (dir == 1), wrp && (dir == 0)};
            chk($sformatf("rnd%0d_irq", t), {31'b0, irq[ch]}, {31'b0, |(exp_sts[3:0] & ie[3:0])});
            model(p, per, l, dir, ar, mx, ecnt, wrp, een);
            exp_sts = {28'b0, (l > per), 1'b1, wrp && (dir == 1), wrp && (dir == 0)};
            rd_chk($sformatf("rnd%0d_sts", t), base + 16, exp_sts);
            model(p, per, l, dir, ar, mx + 1, ecnt, wrp, een);
            rd_chk($sformatf("rnd%0d_cntrd", t), base + 12, ecnt);
            model(p, per, l, dir, ar, mx + 2, ecnt, wrp, een);
            exp_cfg = {20'b0, ie[3:0], 3'b0, dir[0], 2'b0, ar[0], een};
            rd_chk($sformatf("rnd%0d_cfg", t), base, exp_cfg);
        end

        // reset in the middle of counting
        wr(32'h20, 32'h103, 4'hF);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_cnt", cnt_of(0) | cnt_of(1) | cnt_of(2) | cnt_of(3), 32'h0);
        chk("midrst_irq", {28'b0, irq}, 32'h0);
        rd_chk("midrst_cfg1", 32'h20, 32'h2);
        rd_chk("midrst_psc0", 32'h04, 32'h1B);
        rd_chk("midrst_sts1", 32'h30, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
